// File: rtl/trace_uart_if.sv
// Trace port bundle: core-side sample inputs plus the UART line and status flags.
interface trace_uart_if;
  logic        sample_valid;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [31:0] alu_out;
  logic        tx;
  logic        busy;
  logic        overflow;

  modport master (
    output sample_valid, pc, instruction, alu_out,
    input  tx, busy, overflow
  );

  modport slave (
    input  sample_valid, pc, instruction, alu_out,
    output tx, busy, overflow
  );
endinterface

// File: rtl/trace_uart.sv
// Debug trace streamer: snapshots {pc, instruction, alu_out}, queues records, sends A5-framed UART 8N1.
// Optional macro TRACE_CHECKSUM_EN appends an XOR checksum byte over the 12 payload bytes.
module trace_uart #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned DEPTH  = 4
) (
  input  logic         clk,
  input  logic         reset,
  trace_uart_if.slave  bus
);

  localparam int unsigned CPB = CLK_HZ / BAUD;
  localparam int unsigned CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned RW  = 96;
  localparam int unsigned BIW = 4;
`ifdef TRACE_CHECKSUM_EN
  localparam int unsigned NBYTES = 14;
`else
  localparam int unsigned NBYTES = 13;
`endif
  localparam logic [7:0]    SYNC     = 8'hA5;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] BAUD_END = CW'(CPB - 1);
  localparam logic [BIW-1:0] LAST_BYTE = BIW'(NBYTES - 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] alu_out;
  } rec_t;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_e;

  st_e             state, state_d;
  rec_t            mem [DEPTH];
  rec_t            wr_rec;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count, count_d;
  logic            full, empty, push, pop, drop;
  logic [RW-1:0]   shadow;
  logic [CW-1:0]   baud_cnt, baud_d;
  logic [2:0]      bit_idx, bit_d;
  logic [BIW-1:0]  byte_idx, byte_d;
  logic            tx_q, tx_d;
  logic            busy_q, ovf_q;
  logic            byte_end;
  logic            baud_end;
  logic [7:0]      cur_byte;
`ifdef TRACE_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  assign wr_rec   = '{pc: bus.pc, instruction: bus.instruction, alu_out: bus.alu_out};
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push     = bus.sample_valid && (!full || pop);
  assign drop     = bus.sample_valid && full && !pop;
  assign baud_end = (baud_cnt == BAUD_END);

  // Byte on the wire: sync, then shadow MSB byte (shadow shifts after each payload byte), then checksum
  always_comb begin
    cur_byte = shadow[RW-1 -: 8];
    if (byte_idx == '0) begin
      cur_byte = SYNC;
    end
`ifdef TRACE_CHECKSUM_EN
    else if (byte_idx == LAST_BYTE) begin
      cur_byte = csum;
    end
`endif
  end

  always_comb begin
    count_d = count;
    case ({push, pop})
      2'b10:   count_d = count + (AW+1)'(1);
      2'b01:   count_d = count - (AW+1)'(1);
      default: count_d = count;
    endcase
  end

  // Sequencer and bit engine share one FSM: IDLE pops, START/DATA/STOP serialise each byte
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d  = state;
    baud_d   = baud_cnt;
    bit_d    = bit_idx;
    byte_d   = byte_idx;
    tx_d     = tx_q;
    pop      = 1'b0;
    byte_end = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
          baud_d  = '0;
          byte_d  = '0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = cur_byte[0];
        end else begin
          baud_d = baud_cnt + CW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_idx + 3'd1;
            tx_d  = cur_byte[bit_d];
          end
        end else begin
          baud_d = baud_cnt + CW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d   = '0;
          byte_end = 1'b1;
          if (byte_idx == LAST_BYTE) begin
            state_d = IDLE;
          end else begin
            state_d = START;
            byte_d  = byte_idx + BIW'(1);
            tx_d    = 1'b0;
          end
        end else begin
          baud_d = baud_cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_rec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      shadow   <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      count    <= count_d;
      baud_cnt <= baud_d;
      bit_idx  <= bit_d;
      byte_idx <= byte_d;
      tx_q     <= tx_d;
      busy_q   <= (count_d != '0) || (state_d != IDLE);
      ovf_q    <= ovf_q | drop;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        shadow <= mem[rd_ptr];
      end else if (byte_end && byte_idx != '0) begin
        shadow <= {shadow[RW-9:0], 8'h00};
      end
    end
  end

`ifdef TRACE_CHECKSUM_EN
  // Running XOR of payload bytes, folded in as each one finishes
  always_ff @(posedge clk) begin
    if (reset || pop) begin
      csum <= '0;
    end else if (byte_end && byte_idx != '0 && byte_idx != LAST_BYTE) begin
      csum <= csum ^ cur_byte;
    end
  end
`endif

  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = ovf_q;

endmodule

// File: doc/trace_uart.md
# trace_uart

Debug trace port that sits downstream of the pipelined processor core, alongside the PC LED display. On each processor step strobe it snapshots the core's PC, instruction and ALU result, buffers the snapshot in a small record FIFO, and streams it out as a framed byte sequence over a UART 8N1 transmit line. It runs on the 50 MHz board clock, so trace streaming is independent of the divided core clock.

## Interface
Parameters:
- CLK_HZ, 50000000, board clock frequency in Hz.
- BAUD, 115200, UART bit rate. CLKS_PER_BIT = CLK_HZ/BAUD (integer division, must be ≥ 2).
- DEPTH, 4, record FIFO depth. Must be a power of two, ≥ 2.

Ports:
- clk  in  1  board clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sample_valid  in  1  one-cycle pulse in the clk domain, asserted once per core clock edge; qualifies the three data inputs.
- pc  in  32  core program counter.
- instruction  in  32  core instruction word.
- alu_out  in  32  core ALU result.
- tx  out  1  UART serial output; idles high.
- busy  out  1  high while the FIFO is non-empty or a record is being sent.
- overflow  out  1  sticky flag: a sample was dropped because the FIFO was full.

## Operation
- Record: the 96-bit concatenation {pc, instruction, alu_out}, captured on a cycle where sample_valid is high.
- FIFO behaviour:
  - A push happens when sample_valid is high and the FIFO is not full.
  - If sample_valid is high while the FIFO is full and no pop happens that cycle, the sample is dropped and overflow is set. overflow clears only on reset.
  - If a push and a pop happen in the same cycle while full, the push is accepted and count is unchanged.
  - Read and write pointers wrap modulo DEPTH.
- Frame: 13 bytes, sent in this order:
  - Byte 0: sync byte 0xA5.
  - Bytes 1-4: pc, MSB first.
  - Bytes 5-8: instruction, MSB first.
  - Bytes 9-12: alu_out, MSB first.
- Sequencer states:
  - IDLE: when the FIFO is non-empty, pop one record into a 96-bit shadow register, set byte index to 0, go to SEND.
  - SEND: hand the current byte to the bit engine. When the byte completes, increment the index. After the last byte, go to IDLE.
  - A new record is popped only after the previous frame's last stop bit ends. Frames are never interleaved.
- Bit engine states:
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1 and reloads to 0 on every state change.
- busy = (FIFO count ≠ 0) OR (sequencer ≠ IDLE).
- Reset mid-frame: the frame is abandoned immediately. tx returns high on the next edge, and the FIFO, pointers, counters and overflow are cleared.

## Timing
- Reset values: tx=1, busy=0, overflow=0, FIFO count 0, sequencer IDLE, bit engine idle.
- Latency, from sample_valid high in cycle N with an empty FIFO and idle sequencer:
  - Record written at the edge ending cycle N.
  - Popped at the edge ending N+1.
  - tx falls (start bit) in cycle N+2.
- busy rises in cycle N+1.
- Bit duration is exactly CLKS_PER_BIT cycles. Byte duration is 10·CLKS_PER_BIT cycles.
- Frame duration is 130·CLKS_PER_BIT cycles, with no idle gap between bytes of a frame.
- Consecutive queued records: the next start bit begins in the cycle after the previous stop bit ends, plus one cycle for the pop.
- busy falls in the cycle after the final stop bit completes, provided the FIFO is empty.

## Configuration
- Macro: TRACE_CHECKSUM_EN.
- Defined:
  - A 14th byte is appended: the XOR of frame bytes 1-12 (0xA5 excluded).
  - Frame duration becomes 140·CLKS_PER_BIT cycles.
  - The checksum is accumulated as bytes are loaded and is cleared at each pop.
- Undefined: 13-byte frames as above. No checksum logic is instantiated.

## Test plan
All scenarios use CLK_HZ=1000, BAUD=100 (CLKS_PER_BIT=10), DEPTH=4.
- Reset: hold reset 3 cycles, then release -> tx=1, busy=0, overflow=0, and tx stays high for 200 cycles with no sample.
- Single record: pulse sample_valid with pc=0x00000004, instruction=0x00500093, alu_out=0x00000005 -> start bit at N+2; the bus decodes to A5 00 00 00 04 00 50 00 93 00 00 00 05 (checksum build: an extra byte 0xC2); busy falls after 1300 (1400 with checksum) cycles.
- Back-to-back: 4 samples on consecutive cycles -> 4 frames in order, each separated by one extra idle-high cycle; overflow stays 0.
- Overflow: 6 samples on consecutive cycles while the first frame is still being sent -> the first sample is popped into the shadow register, the next 4 fill the FIFO, the 6th is dropped; exactly 5 frames are emitted and overflow=1.
- Reset mid-frame: assert reset during byte 3 -> tx=1 on the next edge, busy=0, and no further transitions occur.
- Full plus simultaneous pop: with the FIFO full, coincide sample_valid with the pop cycle -> the sample is accepted, overflow stays 0, and every queued frame is later emitted intact.
